// File: rtl/psram_pkg.sv
// psram_pkg: command bytes, responder FSM states and
// address geometry shared by the PSRAM responder files.
package psram_pkg;

  localparam int PSRAM_AW = 23;
  // The address phase carries one nibble per 4 bits of a 24-bit field.
  localparam int ADDR_NIBS = (PSRAM_AW + 1) / 4;

  localparam logic [7:0] CMD_RSTEN   = 8'h66;
  localparam logic [7:0] CMD_RST     = 8'h99;
  localparam logic [7:0] CMD_SPI2QPI = 8'h35;
  localparam logic [7:0] CMD_QPI2SPI = 8'hF5;
  localparam logic [7:0] CMD_READ    = 8'hEB;
  localparam logic [7:0] CMD_WRITE   = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: 2^ADDR_W x 8 single-port RAM.
// Ports: clk, we, addr, wdata in; rdata out (registered, read-first).
import psram_pkg::*;

module psram_resp_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rd_q <= mem[addr];
  end

  assign rdata = rd_q;

endmodule

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: LY68L6400-style PSRAM device model (SPI init, QPI
// 0x38 write / 0xEB read into a byte array). Ports: mem_clk, rst, mem_ce,
// mem_sio_in in; mem_sio_out, mem_sio_oe, qpi_mode, last_cmd, cmd_err out.
// Optional power-up lockout: define PSRAM_RESP_BOOT_DELAY_EN.
import psram_pkg::*;

module psram_qpi_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 6,
  parameter int BOOT_CYCLES = 12600
) (
  input  logic       mem_clk,
  input  logic       rst,
  input  logic       mem_ce,
  input  logic [3:0] mem_sio_in,
  output logic [3:0] mem_sio_out,
  output logic       mem_sio_oe,
  output logic       qpi_mode,
  output logic [7:0] last_cmd,
  output logic       cmd_err
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        hi_q, hi_d;
  logic              ph_q, ph_d;
  logic              armed_q, armed_d;
  logic              qpi_q, qpi_d;
  logic [7:0]        last_q, last_d;
  logic              err_q, err_d;
  logic [3:0]        out_q, out_d;
  logic              oe_q, oe_d;
  logic              we;
  logic [7:0]        wdata, rdata;
  logic [7:0]        cmd_byte;
  logic [7:0]        cmd_lim;
  logic              boot_done;

`ifdef PSRAM_RESP_BOOT_DELAY_EN
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  logic [BW-1:0] boot_q, boot_d;

  assign boot_done = (boot_q == BW'(BOOT_CYCLES));

  always_comb begin
    boot_d = boot_q;
    if (!boot_done) boot_d = boot_q + 1'b1;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) boot_q <= '0;
    else     boot_q <= boot_d;
  end
`else
  // No lockout: ready right after reset.
  assign boot_done = (BOOT_CYCLES >= 0);
`endif

  // The byte being completed on this edge, in either bus mode.
  assign cmd_byte = qpi_q ? {sr_q[3:0], mem_sio_in}
                          : {sr_q[6:0], mem_sio_in[0]};
  assign cmd_lim  = qpi_q ? 8'd1 : 8'd7;
  assign wdata    = {hi_q, mem_sio_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    ph_d    = ph_q;
    armed_d = armed_q;
    qpi_d   = qpi_q;
    last_d  = last_q;
    err_d   = err_q;
    we      = 1'b0;
    if (mem_ce) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ph_d    = 1'b0;
    end else if (!boot_done) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        // The CE-low edge that leaves IDLE already carries bit/nibble 0.
        ST_IDLE, ST_CMD: begin
          state_d = ST_CMD;
          sr_d    = cmd_byte;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == cmd_lim) begin
            cnt_d   = '0;
            last_d  = cmd_byte;
            armed_d = 1'b0;
            state_d = ST_IGNORE;
            unique case (1'b1)
              (cmd_byte == CMD_RSTEN): armed_d = 1'b1;
              (cmd_byte == CMD_RST): begin
                if (armed_q) qpi_d = 1'b0;
                else         err_d = 1'b1;
              end
              (cmd_byte == CMD_SPI2QPI && !qpi_q): qpi_d = 1'b1;
              (cmd_byte == CMD_QPI2SPI && qpi_q):  qpi_d = 1'b0;
              ((cmd_byte == CMD_READ ||
                cmd_byte == CMD_WRITE) && qpi_q): state_d = ST_ADDR;
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          // Shifting keeps only the low ADDR_W bits of the 24-bit field.
          addr_d = ADDR_W'({addr_q, mem_sio_in});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == 8'(ADDR_NIBS - 1)) begin
            cnt_d   = '0;
            ph_d    = 1'b0;
            state_d = (last_q == CMD_READ) ? ST_RD_WAIT : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (!ph_q) begin
            hi_d = mem_sio_in;
            ph_d = 1'b1;
          end else begin
            we     = 1'b1;
            addr_d = addr_q + 1'b1;
            ph_d   = 1'b0;
          end
        end
        ST_RD_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
            cnt_d   = '0;
            ph_d    = 1'b0;
            state_d = ST_RD_DATA;
          end
        end
        // Address moves on the high-nibble edge so the RAM fetches A+1
        // on the following edge, while A's low nibble is on the bus.
        ST_RD_DATA: begin
          ph_d = !ph_q;
          if (!ph_q) addr_d = addr_q + 1'b1;
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      ph_q    <= 1'b0;
      armed_q <= 1'b0;
      qpi_q   <= 1'b0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      ph_q    <= ph_d;
      armed_q <= armed_d;
      qpi_q   <= qpi_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    oe_d  = (state_q == ST_RD_DATA);
    out_d = 4'h0;
    if (oe_d) out_d = ph_q ? rdata[3:0] : rdata[7:4];
  end

  always_ff @(negedge mem_clk or posedge rst) begin
    if (rst) begin
      out_q <= 4'h0;
      oe_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (mem_clk),
    .we    (we),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign mem_sio_out = out_q;
  assign mem_sio_oe  = oe_q;
  assign qpi_mode    = qpi_q;
  assign last_cmd    = last_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: command-table checks, hand-written burst
// corner cases and random bursts against a byte-array model.
module tb_psram_qpi_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int WAIT  = 6;
`ifdef PSRAM_RESP_BOOT_DELAY_EN
  localparam int BOOT  = 100;
`else
  localparam int BOOT  = 12600;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] sio;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       qpi;
  logic [7:0] last;
  logic       err;

  psram_qpi_responder #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (WAIT),
    .BOOT_CYCLES (BOOT)
  ) dut (
    .mem_clk     (clk),
    .rst         (rst),
    .mem_ce      (ce),
    .mem_sio_in  (sio),
    .mem_sio_out (sio_out),
    .mem_sio_oe  (sio_oe),
    .qpi_mode    (qpi),
    .last_cmd    (last),
    .cmd_err     (err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mdl [DEPTH];
  logic [7:0] wbuf [16];
  logic [3:0] obs_out;
  logic       obs_oe;

  typedef struct {
    bit         rb;
    bit         q;
    logic [7:0] cmd;
    bit         eq;
    logic [7:0] el;
    bit         ee;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Drive inputs just after a negedge; capture what the DUT drove there.
  task automatic step(input logic c, input logic [3:0] d);
    @(negedge clk);
    #1;
    obs_out = sio_out;
    obs_oe  = sio_oe;
    ce  = c;
    sio = d;
  endtask

  task automatic end_cs();
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    rst = 1'b0;
`ifdef PSRAM_RESP_BOOT_DELAY_EN
    repeat (BOOT + 5) step(1'b1, 4'h0);
`endif
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(1'b0, {3'b000, b[i]});
    end_cs();
  endtask

  task automatic qpi_cmd(input logic [7:0] b);
    step(1'b0, b[7:4]);
    step(1'b0, b[3:0]);
    end_cs();
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int k = 5; k >= 0; k--) step(1'b0, a[k*4 +: 4]);
  endtask

  task automatic qpi_write(input logic [23:0] a, input int n,
                           input bit odd);
    step(1'b0, 4'h3);
    step(1'b0, 4'h8);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      step(1'b0, wbuf[i][7:4]);
      step(1'b0, wbuf[i][3:0]);
      mdl[(int'(a) + i) % DEPTH] = wbuf[i];
    end
    if (odd) step(1'b0, 4'($urandom));
    end_cs();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    step(1'b0, 4'hE);
    step(1'b0, 4'hB);
    send_addr(a);
    for (int w = 0; w < WAIT; w++) step(1'b0, 4'h0);
    chk("rd_wait_oe", obs_oe, 0);
    for (int j = 0; j < 2 * n; j++) begin
      step(1'b0, 4'h0);
      b = mdl[(int'(a) + j / 2) % DEPTH];
      chk("rd_nib", obs_out, (j % 2) ? b[3:0] : b[7:4]);
      chk("rd_oe", obs_oe, 1);
    end
    end_cs();
    chk("rd_end_oe", obs_oe, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    int n;

    vt[0]  = '{1'b0, 1'b0, 8'h66, 1'b0, 8'h66, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h35, 1'b1, 8'h35, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 8'h66, 1'b1, 8'h66, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 8'h35, 1'b1, 8'h35, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 8'hF5, 1'b0, 8'hF5, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 8'hEB, 1'b0, 8'hEB, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 8'h35, 1'b1, 8'h35, 1'b0};
    vt[10] = '{1'b0, 1'b1, 8'h35, 1'b1, 8'h35, 1'b1};
    vt[11] = '{1'b1, 1'b0, 8'h66, 1'b0, 8'h66, 1'b0};
    vt[12] = '{1'b0, 1'b0, 8'h35, 1'b1, 8'h35, 1'b0};
    vt[13] = '{1'b0, 1'b1, 8'h99, 1'b1, 8'h99, 1'b1};
    vt[14] = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1};

    rst = 1'b1;
    ce  = 1'b1;
    sio = 4'h0;
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    chk("rst_out", sio_out, 0);
    chk("rst_oe", sio_oe, 0);
    chk("rst_qpi", qpi, 0);
    chk("rst_last", last, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

`ifdef PSRAM_RESP_BOOT_DELAY_EN
    repeat (42) step(1'b1, 4'h0);
    spi_cmd(8'h66);
    chk("boot_early_last", last, 8'h00);
    chk("boot_early_err", err, 0);
    repeat (90) step(1'b1, 4'h0);
    spi_cmd(8'h66);
    chk("boot_late_last", last, 8'h66);
    do_reset();
`endif

    for (int i = 0; i < 15; i++) begin
      if (vt[i].rb) do_reset();
      if (vt[i].q) qpi_cmd(vt[i].cmd);
      else         spi_cmd(vt[i].cmd);
      chk($sformatf("tbl%0d_qpi", i), qpi, vt[i].eq);
      chk($sformatf("tbl%0d_last", i), last, vt[i].el);
      chk($sformatf("tbl%0d_err", i), err, vt[i].ee);
    end

    do_reset();
    spi_cmd(8'h35);
    chk("qpi_on", qpi, 1);

    wbuf[0] = 8'hAB;
    wbuf[1] = 8'hCD;
    qpi_write(24'h000010, 2, 1'b0);
    qpi_read(24'h000010, 2);

    wbuf[0] = 8'h12;
    wbuf[1] = 8'h34;
    qpi_write(24'(DEPTH - 1), 2, 1'b0);
    qpi_read(24'(DEPTH - 1), 2);
    qpi_read(24'h000000, 1);
    chk("wrap_top", mdl[DEPTH-1], 8'h12);
    chk("wrap_zero", mdl[0], 8'h34);

    step(1'b0, 4'hE);
    step(1'b0, 4'hB);
    send_addr(24'h000010);
    for (int w = 0; w < WAIT; w++) step(1'b0, 4'h0);
    step(1'b1, 4'h0);
    chk("cut_nib0", obs_out, 4'hA);
    chk("cut_oe1", obs_oe, 1);
    step(1'b1, 4'h0);
    chk("cut_oe0", obs_oe, 0);
    qpi_read(24'(DEPTH - 1), 1);
    chk("cut_err", err, 0);

    a = 24'($urandom);
    step(1'b0, 4'h3);
    step(1'b0, 4'h8);
    send_addr(a);
    for (int i = 0; i < DEPTH; i++) begin
      wbuf[0] = 8'($urandom);
      step(1'b0, wbuf[0][7:4]);
      step(1'b0, wbuf[0][3:0]);
      mdl[(int'(a) + i) % DEPTH] = wbuf[0];
    end
    end_cs();

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0)
        a = {$urandom_range(0, 255), 16'(DEPTH - $urandom_range(1, 4))};
      else
        a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        qpi_write(a, n, $urandom_range(0, 1) == 1);
      end else begin
        qpi_read(a, $urandom_range(1, 6));
      end
    end

    a = 24'h000123;
    step(1'b0, 4'hE);
    step(1'b0, 4'hB);
    send_addr(a);
    for (int w = 0; w < WAIT; w++) step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", sio_oe, 0);
    chk("mid_rst_out", sio_out, 0);
    chk("mid_rst_qpi", qpi, 0);
    do_reset();
    spi_cmd(8'h35);
    qpi_read(a, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/psram_qpi_responder.md
# psram_qpi_responder

Synthesizable LY68L6400-style PSRAM responder: the device end of the quad-SPI link that `psram` drives. It decodes SPI-mode initialization commands, switches to QPI, serves 0x38 writes and 0xEB reads into a small on-chip byte array, and drives read data back on the shared nibble bus. It sits in the loopback build and in the testbench in place of the physical chip, wired to `mem_ce` and the `mem_sio` bus.

## Interface
- `ADDR_W`, 10: byte-array address width; depth = 2^ADDR_W bytes; upper bits of the 23-bit address are ignored.
- `WAIT_CYCLES`, 6: QPI read wait nibble-cycles between the last address nibble and the first data nibble.
- `BOOT_CYCLES`, 12600: power-up lockout length in `mem_clk` cycles (150 us at 84 MHz); used only with `PSRAM_RESP_BOOT_DELAY_EN`.
- `mem_clk`  in  1  link clock; bus sampled on posedge, outputs updated on negedge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_ce`  in  1  chip enable, active low.
- `mem_sio_in`  in  4  bus as seen from the pad.
- `mem_sio_out`  out  4  nibble driven during read data.
- `mem_sio_oe`  out  1  output enable for `mem_sio_out`.
- `qpi_mode`  out  1  high once 0x35 has been accepted.
- `last_cmd`  out  8  most recent fully received command byte.
- `cmd_err`  out  1  sticky; set on an unknown command or on RST without a preceding RSTEN.

## Operation
- Reset values: `mem_sio_out`=0, `mem_sio_oe`=0, `qpi_mode`=0, `last_cmd`=0, `cmd_err`=0, state IDLE. Array contents are not reset.
- States: IDLE, CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE.
- IDLE leaves to CMD on the first posedge with `mem_ce`=0.
- In any state, a posedge with `mem_ce`=1 returns the FSM to IDLE and clears the nibble counter. `mem_sio_oe` drops at the next negedge.
- CMD, SPI mode: 8 bits are taken MSB-first from `mem_sio_in[0]`. Accepted commands:
  - 0x66 arms reset.
  - 0x99 performs a reset only if armed: `qpi_mode` goes to 0. Any other command disarms.
  - 0x35 sets `qpi_mode`.
- CMD, QPI mode: 2 nibbles, high nibble first. Accepted commands:
  - 0xEB and 0x38 go to ADDR.
  - 0xF5 clears `qpi_mode`.
  - 0x66 and 0x99 behave as in SPI mode.
- Unknown commands, and reads or writes issued in SPI mode, set `cmd_err` and go to IGNORE until CE rises.
- ADDR: 6 nibbles, MSB first. The 24-bit address is formed and the low `ADDR_W` bits are kept.
- WR_DATA: pairs of nibbles form bytes, high nibble first.
  - Each byte is committed on its second nibble, then the address increments.
  - A trailing odd nibble is discarded when CE rises.
- RD_WAIT: counts `WAIT_CYCLES` posedges, then moves to RD_DATA.
- RD_DATA: drives the high nibble then the low nibble of each byte, with the address incrementing per byte, until CE rises.
- Address arithmetic is modulo 2^ADDR_W, so both read and write bursts wrap to 0.

## Timing
- All bus sampling happens on posedge. `mem_sio_out` and `mem_sio_oe` are registered on negedge, so they are stable at the initiator's sampling posedge.
- Read latency: the first data nibble appears on the negedge following the last RD_WAIT posedge. `mem_sio_oe` rises on that same negedge.
- The array read is registered: the byte for address A+1 is fetched while A's low nibble is being driven. There is no bubble between bytes.
- A write committed at posedge N is visible to a read command that starts at or after posedge N+1.
- `last_cmd`, `qpi_mode` and `cmd_err` update on the posedge that completes the command byte.
- If `rst` is asserted mid-burst, outputs go to their reset values immediately. A partially assembled byte is lost; bytes already committed are kept.

## Configuration
- `PSRAM_RESP_BOOT_DELAY_EN`
  - Defined: a counter runs `BOOT_CYCLES` after `rst` deasserts. Until it expires, the FSM stays in IDLE and ignores CE, and `cmd_err` is not set. This checks the initiator's startup delay.
  - Undefined: the responder is ready on the first cycle after reset.

## Structure
- Shared package `psram_pkg`:
  - command constants CMD_RSTEN 0x66, CMD_RST 0x99, CMD_SPI2QPI 0x35, CMD_QPI2SPI 0xF5, CMD_READ 0xEB, CMD_WRITE 0x38;
  - the FSM state enum;
  - the 23-bit address width constant.
- One sub-module: `psram_resp_mem`, a 2^ADDR_W x 8 single-port RAM with synchronous write and registered read.

## Test plan
- SPI 0x66, 0x99, 0x35 on `mem_sio_in[0]` with CE pulses between them -> `qpi_mode`=1, `last_cmd`=0x35, `cmd_err`=0.
- SPI 0x99 without a prior 0x66 -> `cmd_err`=1 and `qpi_mode` unchanged.
- QPI write 0x38, addr 0x000010, data nibbles A,B,C,D, then read 0xEB at 0x000010 -> after 6 wait cycles the bus shows A,B,C,D with `mem_sio_oe`=1.
- Write at byte address 2^ADDR_W−1 with data 0x1234 -> byte 0x12 lands at top, byte 0x34 at 0; a read from the top address returns 1,2,3,4.
- Mid-read CE rise after 1 data nibble -> `mem_sio_oe`=0 on the next negedge, state IDLE; the next command decodes correctly.
- With `PSRAM_RESP_BOOT_DELAY_EN` and `BOOT_CYCLES`=100, send 0x66 at cycle 50 -> ignored (`last_cmd`=0); the same command at cycle 150 -> `last_cmd`=0x66.
